// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port integer register file with a
// per-register pending scoreboard and a sequenced bulk-clear engine.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   we         write enable from write-back
//   waddr      write address (AW bits)
//   wdata      write data (XLEN bits)
//   raddr      packed read addresses, port k at [k*AW +: AW]
//   rdata      packed read data, port k at [k*XLEN +: XLEN] (combinational)
//   rpend      port k high when the pending bit of raddr[k] is set
//   mark_en    decode marks mark_rd as pending (new producer issued)
//   mark_rd    destination register to mark
//   clr_req    request a bulk clear of all registers
//   clr_busy   high while the clear sequence runs
//
// Optional build macro: RF_BYPASS_EN enables same-cycle write-through
// forwarding from the write port to every read port.
//
// Clear contract: clr_req is sampled only in IDLE. Once accepted, clr_busy
// stays high for exactly NREGS-1 cycles; during that time we, mark_en and
// clr_req are ignored and not queued.

module regfile_mp #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [XLEN-1:0]     wdata,
   input  logic [NRD*AW-1:0]   raddr,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]      rpend,
   input  logic                mark_en,
   input  logic [AW-1:0]       mark_rd,
   input  logic                clr_req,
   output logic                clr_busy
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
   localparam logic [AW-1:0] FIRST_IDX = AW'(1);

   state_t          state_q, state_d;
   logic [AW-1:0]   idx_q;
   logic [XLEN-1:0] regs_q [NREGS];
   logic [NREGS-1:0] pend_q;

   logic wr_ok;
   logic mark_ok;

   // Writes and marks to x0 are discarded; both are only honoured in IDLE.
   assign wr_ok   = (state_q == S_IDLE) && we && (waddr != '0);
   assign mark_ok = (state_q == S_IDLE) && mark_en && (mark_rd != '0);

   // Clear FSM: next-state and outputs
   always_comb begin
      state_d  = state_q;
      clr_busy = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (clr_req) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            clr_busy = 1'b1;
            if (idx_q == LAST_IDX) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Clear FSM: state and sweep index. Index 0 is never swept since x0
   // is permanently zero; the sweep covers 1..NREGS-1.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE) begin
            if (clr_req) idx_q <= FIRST_IDX;
         end else begin
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + FIRST_IDX;
         end
      end
   end

   // Register array
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (state_q == S_CLEAR) begin
         regs_q[idx_q] <= '0;
      end else if (wr_ok) begin
         regs_q[waddr] <= wdata;
      end
   end

   // Pending scoreboard. The mark is assigned after the write-back clear so
   // that a same-register collision leaves the bit set (the new producer
   // wins). An accepted clear request wipes every pending bit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_q <= '0;
      end else if (state_q == S_IDLE) begin
         if (clr_req) begin
            pend_q <= '0;
         end else begin
            if (wr_ok)   pend_q[waddr]   <= 1'b0;
            if (mark_ok) pend_q[mark_rd] <= 1'b1;
         end
      end
   end

   // Read ports
   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd;
      logic            rp;

      assign ra = raddr[k*AW +: AW];

      always_comb begin
         rd = (ra == '0) ? '0 : regs_q[ra];
         rp = (ra != '0) && pend_q[ra];
`ifdef RF_BYPASS_EN
         // Forward the in-flight write; its producer has completed, so the
         // port is not pending unless a new producer marks it this cycle.
         if (wr_ok && (waddr == ra)) begin
            rd = wdata;
            if (!(mark_ok && (mark_rd == ra))) rp = 1'b0;
         end
`endif
      end

      assign rdata[k*XLEN +: XLEN] = rd;
      assign rpend[k]              = rp;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic,
// checked by a monitor against a behavioural model of the register file.

module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int AW    = $clog2(NREGS);
   localparam int EW    = NRD*XLEN + NRD + 1;

   logic                clk;
   logic                reset;
   logic                we;
   logic [AW-1:0]       waddr;
   logic [XLEN-1:0]     wdata;
   logic [NRD*AW-1:0]   raddr;
   logic [NRD*XLEN-1:0] rdata;
   logic [NRD-1:0]      rpend;
   logic                mark_en;
   logic [AW-1:0]       mark_rd;
   logic                clr_req;
   logic                clr_busy;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata), .rpend(rpend), .mark_en(mark_en),
      .mark_rd(mark_rd), .clr_req(clr_req), .clr_busy(clr_busy)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard state
   logic [EW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int busy_seen = 0;

   // reference model: architectural contents, pending flags and the number
   // of clear cycles still to run
   logic [XLEN-1:0] m_reg [NREGS];
   logic            m_pend [NREGS];
   int              m_left = 0;
   bit              m_valid = 0;

   // staged stimulus
   logic              s_reset = 1'b0, s_we = 1'b0, s_mark = 1'b0, s_clr = 1'b0;
   logic [AW-1:0]     s_waddr = '0, s_mark_rd = '0;
   logic [XLEN-1:0]   s_wdata = '0;
   logic [NRD*AW-1:0] s_raddr = '0;

   // driver: apply staged inputs, predict outputs, advance the model
   task automatic tick();
      logic [NRD*XLEN-1:0] ed;
      logic [NRD-1:0]      ep;
      logic [AW-1:0]       a;
      ed = '0;
      ep = '0;
      @(negedge clk);
      reset = s_reset; we = s_we; waddr = s_waddr; wdata = s_wdata;
      mark_en = s_mark; mark_rd = s_mark_rd; clr_req = s_clr; raddr = s_raddr;
      if (m_valid) begin
         for (int k = 0; k < NRD; k++) begin
            a = s_raddr[k*AW +: AW];
            ed[k*XLEN +: XLEN] = (a == 0) ? '0 : m_reg[a];
            ep[k] = (a != 0) && m_pend[a];
`ifdef RF_BYPASS_EN
            if (m_left == 0 && s_we && s_waddr != 0 && s_waddr == a) begin
               ed[k*XLEN +: XLEN] = s_wdata;
               if (!(s_mark && s_mark_rd == a)) ep[k] = 1'b0;
            end
`endif
         end
         exp_q.push_back({(m_left > 0), ep, ed});
      end
      if (!s_reset) begin
         for (int i = 0; i < NREGS; i++) begin
            m_reg[i] = '0;
            m_pend[i] = 1'b0;
         end
         m_left = 0;
         m_valid = 1;
      end else if (m_left > 0) begin
         m_reg[NREGS - m_left] = '0;
         m_left--;
      end else if (s_clr) begin
         if (s_we && s_waddr != 0) m_reg[s_waddr] = s_wdata;
         for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
         m_left = NREGS - 1;
      end else begin
         if (s_we && s_waddr != 0) begin
            m_reg[s_waddr] = s_wdata;
            m_pend[s_waddr] = 1'b0;
         end
         if (s_mark && s_mark_rd != 0) m_pend[s_mark_rd] = 1'b1;
      end
   endtask

   task automatic set_idle();
      s_reset = 1'b1; s_we = 1'b0; s_mark = 1'b0; s_clr = 1'b0;
      s_raddr = (NRD*AW)'($urandom);
   endtask

   task automatic set_rd(input int k, input int a);
      s_raddr[k*AW +: AW] = AW'(a);
   endtask

   task automatic set_wr(input int a, input logic [XLEN-1:0] d);
      s_we = 1'b1; s_waddr = AW'(a); s_wdata = d;
   endtask

   task automatic set_mark(input int a);
      s_mark = 1'b1; s_mark_rd = AW'(a);
   endtask

   task automatic read_all();
      for (int a = 0; a < NREGS; a += 2) begin
         set_idle();
         set_rd(0, a);
         set_rd(1, a + 1);
         tick();
      end
   endtask

   // monitor: every cycle the DUT presents combinational outputs; compare
   // them against the oldest prediction
   always @(negedge clk) begin
      logic [EW-1:0] e, act;
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         act = {clr_busy, rpend, rdata};
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL outputs t=%0t busy/rpend/rdata act=%h exp=%h", $time, act, e);
         end
         if (clr_busy === 1'b1) busy_seen++;
      end
   end

   initial begin
      // reset for two cycles, then every address reads zero / not pending
      s_reset = 1'b0; s_raddr = '0;
      tick();
      tick();
      read_all();

      // plain write and read-back; x0 discards writes
      set_idle(); set_wr(5, 32'hDEADBEEF); tick();
      set_idle(); set_rd(0, 5); tick();
      set_idle(); set_wr(0, 32'h1234); tick();
      set_idle(); set_rd(0, 0); set_rd(1, 0); tick();

      // same-cycle read of the register being written, then next cycle
      set_idle(); set_wr(7, 32'hA5A5A5A5); set_rd(1, 7); tick();
      set_idle(); set_rd(1, 7); tick();

      // scoreboard: mark, set-beats-clear, lone clear
      set_idle(); set_mark(3); set_rd(0, 3); tick();
      set_idle(); set_rd(0, 3); tick();
      set_idle(); set_wr(3, 32'h33); set_mark(3); set_rd(0, 3); tick();
      set_idle(); set_rd(0, 3); tick();
      set_idle(); set_wr(3, 32'h44); set_rd(0, 3); tick();
      set_idle(); set_rd(0, 3); tick();
      // set and clear on different registers
      set_idle(); set_mark(6); tick();
      set_idle(); set_wr(6, 32'h66); set_mark(8); tick();
      set_idle(); set_rd(0, 6); set_rd(1, 8); tick();

      // fill, then bulk clear; a write to x9 mid-sequence must be dropped
      for (int a = 1; a < NREGS; a++) begin
         set_idle(); set_wr(a, $urandom | 32'h1); set_mark(a); tick();
      end
      set_idle(); busy_seen = 0; s_clr = 1'b1; tick();
      for (int c = 0; c < NREGS + 4; c++) begin
         set_idle();
         if (c == 3) begin set_wr(9, 32'h99); set_mark(9); set_rd(0, 9); end
         if (c == 5) s_clr = 1'b1;
         tick();
      end
      @(negedge clk); #3;
      checks++;
      if (busy_seen != NREGS - 1) begin
         errors++;
         $display("FAIL clr_busy_len act=%0d exp=%0d", busy_seen, NREGS - 1);
      end
      read_all();

      // reset in the middle of a clear sequence
      for (int a = 1; a < NREGS; a += 3) begin
         set_idle(); set_wr(a, $urandom | 32'h1); tick();
      end
      set_idle(); s_clr = 1'b1; tick();
      for (int c = 1; c < 10; c++) begin set_idle(); tick(); end
      set_idle(); s_reset = 1'b0; tick();
      read_all();
      set_idle(); set_wr(4, 32'h0404_0404); tick();
      set_idle(); set_rd(0, 4); set_rd(1, 4); tick();

      // random traffic
      for (int n = 0; n < 500; n++) begin
         set_idle();
         s_reset   = ($urandom_range(0, 199) != 0);
         s_we      = 1'($urandom_range(0, 1));
         s_waddr   = AW'($urandom);
         s_wdata   = $urandom;
         s_mark    = ($urandom_range(0, 2) == 0);
         s_mark_rd = ($urandom_range(0, 3) == 0) ? s_waddr : AW'($urandom);
         s_clr     = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 3) == 0) set_rd(0, int'(s_waddr));
         tick();
      end

      set_idle(); tick();
      @(negedge clk); #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain act=%0d exp=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the pipelined RISC-V core. Successor of the 2-read/1-write bank.
- Adds:
  - configurable width, depth and read-port count;
  - a per-register pending scoreboard for the decode-stage hazard check;
  - a sequenced bulk-clear engine used on context flush.
- Sits between the decode stage (reads, scoreboard marks) and write-back (write port).

Parameters:
- XLEN, 32, data width of each register in bits
- NREGS, 32, number of architectural registers (power of two, at least 4); register 0 is hardwired to zero
- NRD, 2, number of read ports (1 to 4)
- AW, $clog2(NREGS), register address width (derived; do not override)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- we  in  1  write enable from WB stage
- waddr  in  AW  write address
- wdata  in  XLEN  write data
- raddr  in  NRD*AW  packed read addresses; port k at bits [k*AW +: AW]
- rdata  out  NRD*XLEN  packed read data; port k at bits [k*XLEN +: XLEN]
- rpend  out  NRD  port k high when the pending bit of raddr[k] is set
- mark_en  in  1  decode issues an instruction that will write mark_rd
- mark_rd  in  AW  destination register to mark pending
- clr_req  in  1  request a bulk clear of all registers
- clr_busy  out  1  high while the clear sequence runs

Behaviour:
- Reset (clk edge with reset==0):
  - all registers set to 0; pending bits set to 0; FSM goes to IDLE with index 0.
  - clr_busy=0. rdata = 0 and rpend = 0 on the following cycle.
- Reads are combinational, zero latency.
  - rdata[k] = reg[raddr[k]]; reading address 0 always returns 0.
  - rpend[k] = pend[raddr[k]]; rpend for address 0 is always 0.
- Write: at a rising edge with FSM in IDLE, we=1 and waddr!=0, reg[waddr] <= wdata. Writes to address 0 are discarded.
- Scoreboard, evaluated per edge while in IDLE:
  - we=1 with waddr!=0 clears pend[waddr].
  - mark_en=1 with mark_rd!=0 sets pend[mark_rd].
  - Set and clear on the same register in the same edge: the set wins (a new producer has issued).
  - Set and clear on different registers: both take effect.
- Clear FSM, two states:
  - IDLE: clr_busy=0. clr_req=1 moves to CLEAR with index=1; all pend bits are zeroed on that same edge.
  - CLEAR: clr_busy=1. Each edge zeroes reg[index] and increments index.
    - When index==NREGS-1, that register is zeroed and the FSM returns to IDLE.
    - Duration is exactly NREGS-1 cycles with clr_busy high.
  - In CLEAR, we, mark_en and clr_req are ignored (not queued). Reads return current contents, so the register file may be partially cleared.
  - Index wraps only through the return to IDLE; it never increments past NREGS-1.
  - reset==0 during CLEAR: immediate full clear and return to IDLE.
- clr_req held high: a new sequence starts on the first IDLE edge after completion.
- No X on any output after the first reset edge.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: same-cycle write-through forwarding.
  - If we=1, waddr!=0, waddr==raddr[k] and FSM is IDLE, rdata[k]=wdata combinationally.
  - rpend[k] is forced to 0 in that case, unless mark_en targets the same register in the same cycle.
- Not defined: reads return the stored value, so a write is visible from the cycle after its edge. rpend reflects the stored pend bit only.

Test Plan:
- Reset low 2 cycles, then high; read all addresses on ports 0/1 -> rdata=0 and rpend=0 everywhere.
- Write x5=0xDEADBEEF, then read raddr[0]=5 next cycle -> 0xDEADBEEF. Write x0=0x1234, then read x0 -> 0.
- Same-cycle write x7=0xA5A5A5A5 while raddr[1]=7 -> 0xA5A5A5A5 with RF_BYPASS_EN, old value (0) without; 0xA5A5A5A5 the next cycle in both builds.
- mark x3; next cycle rpend[0]=1 for raddr 3. Edge with we on x3 plus mark_en on x3 -> still pending. Lone we on x3 -> pending cleared.
- Fill x1..x31 with nonzero values and pulse clr_req -> clr_busy high exactly 31 cycles; a write to x9 during CLEAR is dropped; afterwards all reads 0.
- Pull reset low at cycle 10 of CLEAR -> next cycle clr_busy=0 and all registers 0; a subsequent write to x4 takes effect normally.
